// File: rtl/prn_gen_ctrl_if.sv
// Configuration handshake between the channel manager and the PRN generator sequencer.
// The master side offers a configuration; the slave accepts it or flags it as rejected.
interface prn_gen_ctrl_if #(
  parameter int PRN_PHS_WIDTH = 12,
  parameter int ACC_WIDTH     = 32
);
  logic                     rx_cfg_vld;
  logic [ACC_WIDTH-1:0]     rx_cfg_fcw;
  logic [ACC_WIDTH-1:0]     rx_cfg_init_phs;
  logic [2:0]               rx_cfg_paral;
  logic [PRN_PHS_WIDTH-1:0] rx_cfg_code_len;
  logic [PRN_PHS_WIDTH-1:0] rx_cfg_start_chip;
  logic                     tx_cfg_rdy;
  logic                     tx_cfg_err;

  modport master (
    output rx_cfg_vld, rx_cfg_fcw, rx_cfg_init_phs, rx_cfg_paral,
           rx_cfg_code_len, rx_cfg_start_chip,
    input  tx_cfg_rdy, tx_cfg_err
  );

  modport slave (
    input  rx_cfg_vld, rx_cfg_fcw, rx_cfg_init_phs, rx_cfg_paral,
           rx_cfg_code_len, rx_cfg_start_chip,
    output tx_cfg_rdy, tx_cfg_err
  );
endinterface

// File: rtl/prn_gen_ctrl.sv
// Per-channel sequencer for the BOC/PRN local code generator: latches the channel
// configuration, releases the generator on a time mark and tracks chip index and code epochs.
module prn_gen_ctrl #(
  parameter int PRN_PHS_WIDTH = 12,
  parameter int ACC_WIDTH     = 32,
  parameter int EPOCH_WIDTH   = 16
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst,
  prn_gen_ctrl_if.slave            cfg,
  input  logic                     rx_start,
  input  logic                     rx_time_mark,
  input  logic                     rx_stop,
  input  logic                     rx_slew,
  input  logic [PRN_PHS_WIDTH-1:0] rx_slew_chip,
  input  logic [PRN_PHS_WIDTH-1:0] rx_prn_phs,
  output logic                     tx_gen_rst,
  output logic [ACC_WIDTH-1:0]     tx_prn_fcw,
  output logic [ACC_WIDTH-1:0]     tx_init_phs,
  output logic [2:0]               tx_corr_paral,
  output logic [PRN_PHS_WIDTH-1:0] tx_chip_idx,
  output logic                     tx_epoch,
  output logic [EPOCH_WIDTH-1:0]   tx_epoch_cnt,
  output logic                     tx_busy
);

  typedef enum logic [1:0] {IDLE, WAIT_TM, RUN, SLEW} state_t;

  state_t                   state;
  logic [PRN_PHS_WIDTH-1:0] code_len;
  logic [PRN_PHS_WIDTH-1:0] start_chip;
  logic [PRN_PHS_WIDTH-1:0] prn_phs_d;
  logic                     valid_cfg;
  logic                     cfg_err_q;
  logic                     cfg_legal;
  logic                     chip_adv;
  logic                     last_chip;

  assign cfg_legal      = cfg.rx_cfg_code_len >= PRN_PHS_WIDTH'(2);
  assign chip_adv       = rx_prn_phs != prn_phs_d;
  assign last_chip      = tx_chip_idx == (code_len - PRN_PHS_WIDTH'(1));
  assign cfg.tx_cfg_rdy = state == IDLE;
  assign cfg.tx_cfg_err = cfg_err_q;
  assign tx_busy        = state != IDLE;

  always_ff @(posedge rx_clk) begin
    if (!rx_rst) begin
      state         <= IDLE;
      tx_gen_rst    <= 1'b1;
      tx_prn_fcw    <= '0;
      tx_init_phs   <= '0;
      tx_corr_paral <= '0;
      tx_chip_idx   <= '0;
      tx_epoch      <= 1'b0;
      tx_epoch_cnt  <= '0;
      code_len      <= '0;
      start_chip    <= '0;
      prn_phs_d     <= '0;
      valid_cfg     <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      tx_epoch  <= 1'b0;
      case (state)
        IDLE: begin
          tx_gen_rst <= 1'b1;
          if (cfg.rx_cfg_vld) begin
            if (cfg_legal) begin
              tx_prn_fcw    <= cfg.rx_cfg_fcw;
              tx_init_phs   <= cfg.rx_cfg_init_phs;
              tx_corr_paral <= cfg.rx_cfg_paral;
              code_len      <= cfg.rx_cfg_code_len;
              start_chip    <= cfg.rx_cfg_start_chip;
              valid_cfg     <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          // A legal config offered alongside rx_start arms immediately.
          if (rx_start && (valid_cfg || (cfg.rx_cfg_vld && cfg_legal))) begin
            state <= WAIT_TM;
          end
        end
        WAIT_TM: begin
          if (rx_stop) begin
            state <= IDLE;
          end else if (rx_time_mark) begin
            state        <= RUN;
            tx_gen_rst   <= 1'b0;
            tx_chip_idx  <= start_chip;
            tx_epoch_cnt <= '0;
            prn_phs_d    <= '0;
          end
        end
        RUN: begin
          if (rx_stop) begin
            state      <= IDLE;
            tx_gen_rst <= 1'b1;
          end else if (rx_slew) begin
            state       <= SLEW;
            tx_gen_rst  <= 1'b1;
            tx_chip_idx <= (rx_slew_chip >= code_len) ? '0 : rx_slew_chip;
            prn_phs_d   <= '0;
          end else begin
            prn_phs_d <= rx_prn_phs;
            if (chip_adv) begin
              if (last_chip) begin
                tx_chip_idx  <= '0;
                tx_epoch     <= 1'b1;
                tx_epoch_cnt <= tx_epoch_cnt + EPOCH_WIDTH'(1);
              end else begin
                tx_chip_idx <= tx_chip_idx + PRN_PHS_WIDTH'(1);
              end
            end
          end
        end
        SLEW: begin
          // prn_phs_d stays 0 here because the generator restarts from phase 0.
          tx_gen_rst <= 1'b1;
          if (rx_stop) begin
            state <= IDLE;
          end else begin
            state      <= RUN;
            tx_gen_rst <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          tx_gen_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prn_gen_ctrl.sv
// Directed bench for prn_gen_ctrl: the bench plays the generator by stepping rx_prn_phs
// and checks every expected value against hand-computed constants.
module tb_prn_gen_ctrl;
  localparam int PW = 12;
  localparam int AW = 32;
  localparam int EW = 16;

  logic          rx_clk = 1'b0;
  logic          rx_rst;
  logic          rx_start, rx_time_mark, rx_stop, rx_slew;
  logic [PW-1:0] rx_slew_chip, rx_prn_phs;
  logic          tx_gen_rst, tx_epoch, tx_busy;
  logic [AW-1:0] tx_prn_fcw, tx_init_phs;
  logic [2:0]    tx_corr_paral;
  logic [PW-1:0] tx_chip_idx;
  logic [EW-1:0] tx_epoch_cnt;

  int vectors = 0;
  int miscompares = 0;

  prn_gen_ctrl_if #(.PRN_PHS_WIDTH(PW), .ACC_WIDTH(AW)) cfg_if ();

  prn_gen_ctrl #(.PRN_PHS_WIDTH(PW), .ACC_WIDTH(AW), .EPOCH_WIDTH(EW)) dut (
    .rx_clk        (rx_clk),
    .rx_rst        (rx_rst),
    .cfg           (cfg_if.slave),
    .rx_start      (rx_start),
    .rx_time_mark  (rx_time_mark),
    .rx_stop       (rx_stop),
    .rx_slew       (rx_slew),
    .rx_slew_chip  (rx_slew_chip),
    .rx_prn_phs    (rx_prn_phs),
    .tx_gen_rst    (tx_gen_rst),
    .tx_prn_fcw    (tx_prn_fcw),
    .tx_init_phs   (tx_init_phs),
    .tx_corr_paral (tx_corr_paral),
    .tx_chip_idx   (tx_chip_idx),
    .tx_epoch      (tx_epoch),
    .tx_epoch_cnt  (tx_epoch_cnt),
    .tx_busy       (tx_busy)
  );

  always #5 rx_clk = ~rx_clk;

  // One clock edge; inputs are changed and outputs sampled 1 ns after it.
  task automatic applyStimulus();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Each call is one generator chip: the phase count moves by one.
  task automatic advanceChips(input int n);
    for (int i = 0; i < n; i++) begin
      rx_prn_phs = rx_prn_phs + 1'b1;
      applyStimulus();
    end
  endtask

  task automatic offerCfg(input logic [PW-1:0] len, input logic [PW-1:0] start, input logic [AW-1:0] fcw);
    cfg_if.rx_cfg_vld        = 1'b1;
    cfg_if.rx_cfg_code_len   = len;
    cfg_if.rx_cfg_start_chip = start;
    cfg_if.rx_cfg_fcw        = fcw;
    applyStimulus();
    cfg_if.rx_cfg_vld        = 1'b0;
  endtask

  initial begin
    rx_rst = 1'b0; rx_start = 1'b0; rx_time_mark = 1'b0; rx_stop = 1'b0; rx_slew = 1'b0;
    rx_slew_chip = '0; rx_prn_phs = '0;
    cfg_if.rx_cfg_vld = 1'b0; cfg_if.rx_cfg_fcw = '0; cfg_if.rx_cfg_init_phs = 32'h0000_1234;
    cfg_if.rx_cfg_paral = 3'b101; cfg_if.rx_cfg_code_len = '0; cfg_if.rx_cfg_start_chip = '0;

    // Reset
    applyStimulus();
    applyStimulus();
    checkOutput("rst_gen_rst", tx_gen_rst, 1);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_chip", tx_chip_idx, 0);
    checkOutput("rst_epoch_cnt", tx_epoch_cnt, 0);
    checkOutput("rst_cfg_rdy", cfg_if.tx_cfg_rdy, 1);
    checkOutput("rst_fcw", tx_prn_fcw, 0);
    rx_rst = 1'b1;

    // Illegal cfg with nothing valid yet, then start is ignored
    offerCfg(12'd1, 12'd0, 32'hDEAD_BEEF);
    checkOutput("ill_err_pulse", cfg_if.tx_cfg_err, 1);
    rx_start = 1'b1;
    applyStimulus();
    rx_start = 1'b0;
    checkOutput("ill_err_clear", cfg_if.tx_cfg_err, 0);
    checkOutput("ill_start_ignored", tx_busy, 0);
    checkOutput("ill_fcw_untouched", tx_prn_fcw, 0);

    // Legal cfg, then an illegal one that must not overwrite it
    offerCfg(12'd2046, 12'd0, 32'h1000_0000);
    checkOutput("cfg_err_none", cfg_if.tx_cfg_err, 0);
    checkOutput("cfg_fcw", tx_prn_fcw, 32'h1000_0000);
    checkOutput("cfg_init_phs", tx_init_phs, 32'h0000_1234);
    checkOutput("cfg_paral", tx_corr_paral, 3'b101);
    offerCfg(12'd1, 12'd5, 32'h0BAD_0BAD);
    checkOutput("cfg2_err_pulse", cfg_if.tx_cfg_err, 1);
    checkOutput("cfg2_fcw_kept", tx_prn_fcw, 32'h1000_0000);

    // Arm and release on a time mark five cycles later
    rx_start = 1'b1;
    applyStimulus();
    rx_start = 1'b0;
    checkOutput("arm_busy", tx_busy, 1);
    checkOutput("arm_cfg_rdy", cfg_if.tx_cfg_rdy, 0);
    checkOutput("arm_gen_rst", tx_gen_rst, 1);
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("wait_gen_rst", tx_gen_rst, 1);
    rx_time_mark = 1'b1;
    applyStimulus();
    rx_time_mark = 1'b0;
    checkOutput("rel_gen_rst", tx_gen_rst, 0);
    checkOutput("rel_chip", tx_chip_idx, 0);
    checkOutput("rel_epoch_cnt", tx_epoch_cnt, 0);

    // Chip tracking and epochs
    advanceChips(10);
    checkOutput("run_chip10", tx_chip_idx, 10);
    applyStimulus();
    checkOutput("run_hold10", tx_chip_idx, 10);
    advanceChips(2035);
    checkOutput("run_chip2045", tx_chip_idx, 2045);
    checkOutput("run_no_epoch", tx_epoch, 0);
    advanceChips(1);
    checkOutput("wrap1_chip", tx_chip_idx, 0);
    checkOutput("wrap1_epoch", tx_epoch, 1);
    checkOutput("wrap1_cnt", tx_epoch_cnt, 1);
    applyStimulus();
    checkOutput("wrap1_epoch_clear", tx_epoch, 0);
    advanceChips(4092);
    checkOutput("wrap3_chip", tx_chip_idx, 0);
    checkOutput("wrap3_cnt", tx_epoch_cnt, 3);

    // Time mark while running is ignored
    rx_time_mark = 1'b1;
    applyStimulus();
    rx_time_mark = 1'b0;
    checkOutput("tm_run_chip", tx_chip_idx, 0);
    checkOutput("tm_run_cnt", tx_epoch_cnt, 3);

    // Slew from chip 100 to 2000; phase changes in the slew cycles are discarded
    advanceChips(100);
    checkOutput("pre_slew_chip", tx_chip_idx, 100);
    rx_slew = 1'b1; rx_slew_chip = 12'd2000;
    rx_prn_phs = rx_prn_phs + 1'b1;
    applyStimulus();
    rx_slew = 1'b0;
    checkOutput("slew_gen_rst", tx_gen_rst, 1);
    checkOutput("slew_chip", tx_chip_idx, 2000);
    checkOutput("slew_cnt", tx_epoch_cnt, 3);
    checkOutput("slew_epoch", tx_epoch, 0);
    rx_prn_phs = 12'd7;
    applyStimulus();
    rx_prn_phs = 12'd0;
    checkOutput("slew_back_gen_rst", tx_gen_rst, 0);
    checkOutput("slew_back_chip", tx_chip_idx, 2000);
    applyStimulus();
    checkOutput("slew_no_adv", tx_chip_idx, 2000);
    advanceChips(45);
    checkOutput("slew_chip2045", tx_chip_idx, 2045);
    advanceChips(1);
    checkOutput("slew_wrap_epoch", tx_epoch, 1);
    checkOutput("slew_wrap_cnt", tx_epoch_cnt, 4);

    // Slew target beyond the code length lands on chip 0 without an epoch
    advanceChips(5);
    rx_slew = 1'b1; rx_slew_chip = 12'd3000;
    applyStimulus();
    rx_slew = 1'b0;
    checkOutput("slew_oob_chip", tx_chip_idx, 0);
    checkOutput("slew_oob_epoch", tx_epoch, 0);
    checkOutput("slew_oob_cnt", tx_epoch_cnt, 4);
    rx_prn_phs = 12'd0;
    applyStimulus();

    // Generator phase-counter wrap counts as one advance each way
    rx_prn_phs = 12'd4095;
    applyStimulus();
    checkOutput("phs_to_4095", tx_chip_idx, 1);
    rx_prn_phs = 12'd0;
    applyStimulus();
    checkOutput("phs_wrap", tx_chip_idx, 2);

    // Stop and slew together: stop wins, values hold
    rx_stop = 1'b1; rx_slew = 1'b1; rx_slew_chip = 12'd500;
    rx_prn_phs = rx_prn_phs + 1'b1;
    applyStimulus();
    rx_stop = 1'b0; rx_slew = 1'b0;
    checkOutput("stop_busy", tx_busy, 0);
    checkOutput("stop_gen_rst", tx_gen_rst, 1);
    checkOutput("stop_chip", tx_chip_idx, 2);
    checkOutput("stop_cnt", tx_epoch_cnt, 4);
    applyStimulus();
    checkOutput("stop_idle_rdy", cfg_if.tx_cfg_rdy, 1);

    // Time mark in IDLE is ignored
    rx_time_mark = 1'b1;
    applyStimulus();
    rx_time_mark = 1'b0;
    checkOutput("tm_idle_busy", tx_busy, 0);
    checkOutput("tm_idle_gen_rst", tx_gen_rst, 1);

    // Retained cfg re-arms; stop in WAIT_TM; then a new short code with a start chip
    rx_start = 1'b1;
    applyStimulus();
    rx_start = 1'b0;
    checkOutput("rearm_busy", tx_busy, 1);
    rx_stop = 1'b1;
    applyStimulus();
    rx_stop = 1'b0;
    checkOutput("wait_stop_busy", tx_busy, 0);
    offerCfg(12'd10, 12'd7, 32'h0800_0000);
    rx_start = 1'b1;
    applyStimulus();
    rx_start = 1'b0;
    rx_prn_phs = 12'd0;
    rx_time_mark = 1'b1;
    applyStimulus();
    rx_time_mark = 1'b0;
    checkOutput("short_start_chip", tx_chip_idx, 7);
    checkOutput("short_cnt0", tx_epoch_cnt, 0);
    advanceChips(3);
    checkOutput("short_wrap_chip", tx_chip_idx, 0);
    checkOutput("short_wrap_epoch", tx_epoch, 1);
    checkOutput("short_wrap_cnt", tx_epoch_cnt, 1);

    // Reset mid-run clears everything including the stored cfg
    advanceChips(2);
    rx_rst = 1'b0;
    applyStimulus();
    rx_rst = 1'b1;
    checkOutput("midrst_gen_rst", tx_gen_rst, 1);
    checkOutput("midrst_busy", tx_busy, 0);
    checkOutput("midrst_chip", tx_chip_idx, 0);
    checkOutput("midrst_cnt", tx_epoch_cnt, 0);
    checkOutput("midrst_fcw", tx_prn_fcw, 0);
    rx_start = 1'b1;
    applyStimulus();
    rx_start = 1'b0;
    checkOutput("midrst_start_ignored", tx_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
